// File: rtl/axi4_wr_aux_gen_no_resp_pkg.sv
// Shared types and constants for the AXI4 write-address generator.
package axi4_wr_aux_gen_no_resp_pkg;

   // Transaction phases: waiting for a descriptor, presenting AW, passing W data
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [1:0] INCR = 2'b01;

   // awsize encoding for a data bus of dsize bits (bytes per beat = 2**awsize)
   function automatic logic [2:0] awsize_f(input int dsize);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((8 << i) == dsize) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/axi4_wr_aux_gen_no_resp.sv
// AXI4 write-address generator: one AW per descriptor, then opens the
// external W valve for exactly one burst (closed again on wlast).
module axi4_wr_aux_gen_no_resp
   import axi4_wr_aux_gen_no_resp_pkg::*;
#(
   parameter int IDSIZE = 4,
   parameter int ASIZE  = 32,
   parameter int LSIZE  = 8,
   parameter int DSIZE  = 32
) (
   input  logic                          axi_aclk,
   input  logic                          axi_aresetn,
   input  logic [IDSIZE+ASIZE+LSIZE-1:0] id_add_len_in_tdata,
   input  logic                          id_add_len_in_tvalid,
   input  logic                          id_add_len_in_tlast,
   output logic                          id_add_len_in_tready,
   output logic [IDSIZE-1:0]             axi_awid,
   output logic [ASIZE-1:0]              axi_awaddr,
   output logic [LSIZE-1:0]              axi_awlen,
   output logic [2:0]                    axi_awsize,
   output logic [1:0]                    axi_awburst,
   output logic                          axi_awlock,
   output logic [3:0]                    axi_awcache,
   output logic [2:0]                    axi_awprot,
   output logic [3:0]                    axi_awqos,
   output logic                          axi_awvalid,
   input  logic                          axi_awready,
   input  logic                          axi_wvalid,
   input  logic                          axi_wready,
   input  logic                          axi_wlast,
   output logic                          stream_en
);

   localparam int DW = IDSIZE + ASIZE + LSIZE;

   state_t state;
   logic   w_done;

   // Every descriptor beat is self-contained, so tlast carries no information
   logic unused_tlast;
   assign unused_tlast = id_add_len_in_tlast;

   // Fixed burst attributes: full-width INCR bursts, normal access
   assign axi_awsize  = awsize_f(DSIZE);
   assign axi_awburst = INCR;
   assign axi_awlock  = 1'b0;
   assign axi_awcache = 4'd0;
   assign axi_awprot  = 3'd0;
   assign axi_awqos   = 4'd0;

   // Ready only while idle; masked during reset so nothing is taken then
   assign id_add_len_in_tready = (state == IDLE) && axi_aresetn;

   // Burst end is taken purely from the wlast handshake, beats are not counted
   assign w_done = axi_wvalid && axi_wready && axi_wlast;

   // Sequencer with registered AW payload, awvalid and stream_en
   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state       <= IDLE;
         axi_awvalid <= 1'b0;
         stream_en   <= 1'b0;
         axi_awid    <= '0;
         axi_awaddr  <= '0;
         axi_awlen   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (id_add_len_in_tvalid) begin
                  axi_awid    <= id_add_len_in_tdata[DW-1 -: IDSIZE];
                  axi_awaddr  <= id_add_len_in_tdata[LSIZE +: ASIZE];
                  axi_awlen   <= id_add_len_in_tdata[LSIZE-1:0];
                  axi_awvalid <= 1'b1;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               if (axi_awready) begin
                  axi_awvalid <= 1'b0;
                  stream_en   <= 1'b1;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (w_done) begin
                  stream_en <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               axi_awvalid <= 1'b0;
               stream_en   <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_wr_aux_gen_no_resp.sv
// Self-checking bench: directed scenarios plus randomized bursts, with a
// descriptor/AW/W scoreboard watching every cycle.
module tb_axi4_wr_aux_gen_no_resp;

   logic        clk = 1'b0;
   logic        rstn;
   logic [43:0] tdata;
   logic        tvalid, tlast, tready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic [3:0]  awqos;
   logic        awvalid, awready;
   logic        wvalid, wready, wlast;
   logic        stream_en;

   int n_cmp = 0;
   int n_err = 0;

   logic [43:0] acc_q[$];
   logic [7:0]  len_q[$];
   int          beats = 0;

   always #5 clk = ~clk;

   axi4_wr_aux_gen_no_resp #(.IDSIZE(4), .ASIZE(32), .LSIZE(8), .DSIZE(32)) dut (
      .axi_aclk(clk), .axi_aresetn(rstn),
      .id_add_len_in_tdata(tdata), .id_add_len_in_tvalid(tvalid),
      .id_add_len_in_tlast(tlast), .id_add_len_in_tready(tready),
      .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
      .axi_awburst(awburst), .axi_awlock(awlock), .axi_awcache(awcache),
      .axi_awprot(awprot), .axi_awqos(awqos), .axi_awvalid(awvalid),
      .axi_awready(awready), .axi_wvalid(wvalid), .axi_wready(wready),
      .axi_wlast(wlast), .stream_en(stream_en)
   );

   // Scoreboard: sampled at negedge, i.e. what the coming rising edge will see
   always @(negedge clk) begin
      logic [43:0] d;
      logic [7:0]  l;
      if (!rstn) begin
         beats = 0;
      end else begin
         if (tvalid && tready) acc_q.push_back(tdata);
         if (awvalid && awready) begin
            n_cmp++;
            if (acc_q.size() == 0) begin
               n_err++;
               $display("FAIL aw_unexpected: got id=%0d addr=%h len=%0d, no descriptor pending", awid, awaddr, awlen);
            end else begin
               d = acc_q.pop_front();
               if ({awid, awaddr, awlen} !== d) begin
                  n_err++;
                  $display("FAIL aw_payload: got %h want %h", {awid, awaddr, awlen}, d);
               end
               len_q.push_back(d[7:0]);
            end
         end
         n_cmp++;
         if (awvalid && stream_en) begin
            n_err++;
            $display("FAIL aw_w_overlap: awvalid=%b stream_en=%b want not both", awvalid, stream_en);
         end
         if (stream_en && wvalid && wready) begin
            beats++;
            if (wlast) begin
               n_cmp++;
               if (len_q.size() == 0) begin
                  n_err++;
                  $display("FAIL burst_unexpected: wlast with no AW issued");
               end else begin
                  l = len_q.pop_front();
                  if (beats != int'(l) + 1) begin
                     n_err++;
                     $display("FAIL burst_beats: got %0d want %0d", beats, int'(l) + 1);
                  end
               end
               beats = 0;
            end
         end
      end
   end

   // Offer a descriptor and wait for it to be taken; checks AW one cycle later
   task automatic present(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
      int g = 0;
      tvalid = 1'b1;
      tdata  = {id, a, l};
      while (!tready && g < 30) begin @(posedge clk); #1; g++; end
      n_cmp++;
      if (!tready) begin n_err++; $display("FAIL accept_timeout: tready=%b want 1", tready); end
      @(posedge clk); #1;
      tvalid = 1'b0;
      n_cmp++;
      if ({awvalid, awid, awaddr, awlen} !== {1'b1, id, a, l}) begin
         n_err++;
         $display("FAIL aw_latency: got v=%b id=%0d a=%h l=%0d want v=1 id=%0d a=%h l=%0d",
                  awvalid, awid, awaddr, awlen, id, a, l);
      end
   endtask

   // Hold awready low for `stall` cycles, then complete the AW handshake
   task automatic aw_phase(input int stall, input logic [43:0] d);
      awready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({awvalid, stream_en, tready, awid, awaddr, awlen} !== {3'b100, d}) begin
            n_err++;
            $display("FAIL aw_hold: got v=%b en=%b rdy=%b pl=%h want v=1 en=0 rdy=0 pl=%h",
                     awvalid, stream_en, tready, {awid, awaddr, awlen}, d);
         end
      end
      awready = 1'b1;
      @(posedge clk); #1;
      awready = 1'b0;
      n_cmp++;
      if ({stream_en, awvalid, tready} !== 3'b100) begin
         n_err++;
         $display("FAIL data_entry: got en=%b v=%b rdy=%b want 1 0 0", stream_en, awvalid, tready);
      end
   endtask

   // Push nbeats W beats through, wready from a pattern or random stalls
   task automatic w_phase(input int nbeats, input int stall_max, input logic [15:0] pat, input bit use_pat);
      int  done = 0;
      int  k = 0;
      bit  hs;
      while (done < nbeats && k < 200) begin
         wvalid = 1'b1;
         wlast  = (done == nbeats - 1);
         if (use_pat) wready = pat[k % 16];
         else         wready = (stall_max == 0) ? 1'b1 : ($urandom_range(0, stall_max) == 0);
         n_cmp++;
         if (stream_en !== 1'b1) begin
            n_err++;
            $display("FAIL stream_en_hold: beat %0d got %b want 1", done, stream_en);
         end
         hs = wready;
         @(posedge clk); #1;
         if (hs) done++;
         k++;
      end
      wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
      n_cmp++;
      if ({stream_en, tready, awvalid} !== 3'b010) begin
         n_err++;
         $display("FAIL burst_close: got en=%b rdy=%b v=%b want 0 1 0", stream_en, tready, awvalid);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; tvalid = 1'b1; tdata = {4'd5, 32'hdead_beef, 8'd3};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({tready, awvalid, stream_en} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: cyc %0d got rdy=%b v=%b en=%b want 0 0 0", i, tready, awvalid, stream_en);
         end
      end
      n_cmp++;
      if ({awid, awaddr, awlen} !== 44'd0) begin
         n_err++;
         $display("FAIL reset_payload: got %h want 0", {awid, awaddr, awlen});
      end
      tvalid = 1'b0;
      rstn = 1'b1;
      #1;
      n_cmp++;
      if (tready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", tready); end
      n_cmp++;
      if ({awsize, awburst, awlock, awcache, awprot, awqos} !== {3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0}) begin
         n_err++;
         $display("FAIL const_fields: size=%0d burst=%0d lock=%b cache=%0d prot=%0d qos=%0d want 2 1 0 0 0 0",
                  awsize, awburst, awlock, awcache, awprot, awqos);
      end
   endtask

   task automatic test_single_burst();
      awready = 1'b1;
      present(4'd3, 32'h0000_1000, 8'd7);
      n_cmp++;
      if ({awsize, awburst} !== {3'd2, 2'd1}) begin
         n_err++;
         $display("FAIL single_size_burst: got %0d %0d want 2 1", awsize, awburst);
      end
      aw_phase(0, {4'd3, 32'h0000_1000, 8'd7});
      w_phase(8, 0, 16'h0, 1'b0);
   endtask

   task automatic test_aw_backpressure();
      awready = 1'b0;
      present(4'd9, 32'h8000_0040, 8'd2);
      aw_phase(5, {4'd9, 32'h8000_0040, 8'd2});
      w_phase(3, 0, 16'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      awready = 1'b1;
      present(4'd0, 32'h0000_2000, 8'd0);
      tvalid = 1'b1; tdata = {4'd1, 32'h0000_3000, 8'd3};
      n_cmp++;
      if (tready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_addr: got %b want 0", tready); end
      @(posedge clk); #1;
      n_cmp++;
      if ({stream_en, tready} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_data0: got en=%b rdy=%b want 1 0", stream_en, tready);
      end
      wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
      n_cmp++;
      if ({stream_en, tready, awvalid} !== 3'b010) begin
         n_err++;
         $display("FAIL b2b_idle_gap: got en=%b rdy=%b v=%b want 0 1 0", stream_en, tready, awvalid);
      end
      @(posedge clk); #1;
      tvalid = 1'b0;
      n_cmp++;
      if ({awvalid, awid, awlen, tready} !== {1'b1, 4'd1, 8'd3, 1'b0}) begin
         n_err++;
         $display("FAIL b2b_second_aw: got v=%b id=%0d len=%0d rdy=%b want 1 1 3 0", awvalid, awid, awlen, tready);
      end
      aw_phase(0, {4'd1, 32'h0000_3000, 8'd3});
      w_phase(4, 0, 16'h0, 1'b0);
   endtask

   task automatic test_w_stall();
      awready = 1'b1;
      present(4'd6, 32'h0000_4000, 8'd1);
      aw_phase(0, {4'd6, 32'h0000_4000, 8'd1});
      w_phase(2, 0, 16'b1001, 1'b1);
   endtask

   task automatic test_mid_burst_reset();
      awready = 1'b1;
      present(4'd2, 32'h0000_5000, 8'd7);
      aw_phase(0, {4'd2, 32'h0000_5000, 8'd7});
      wvalid = 1'b1; wready = 1'b1; wlast = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      wvalid = 1'b0; wready = 1'b0;
      rstn = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({stream_en, awvalid} !== 2'b00) begin
         n_err++;
         $display("FAIL midrst_outputs: got en=%b v=%b want 0 0", stream_en, awvalid);
      end
      acc_q.delete(); len_q.delete();
      rstn = 1'b1;
      #1;
      n_cmp++;
      if (tready !== 1'b1) begin n_err++; $display("FAIL midrst_idle: tready got %b want 1", tready); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({awvalid, stream_en} !== 2'b00) begin
         n_err++;
         $display("FAIL midrst_quiet: got v=%b en=%b want 0 0", awvalid, stream_en);
      end
      present(4'd11, 32'h0000_6000, 8'd4);
      aw_phase(1, {4'd11, 32'h0000_6000, 8'd4});
      w_phase(5, 0, 16'h0, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0]  id;
      logic [31:0] a;
      logic [7:0]  l;
      for (int i = 0; i < 25; i++) begin
         id = 4'($urandom);
         a  = $urandom;
         l  = 8'($urandom_range(0, 15));
         awready = 1'($urandom_range(0, 1));
         present(id, a, l);
         aw_phase(int'($urandom_range(0, 3)), {id, a, l});
         w_phase(int'(l) + 1, 2, 16'h0, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
      end
   endtask

   initial begin
      rstn = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b1;
      awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
      test_reset();
      test_single_burst();
      test_aw_backpressure();
      test_back_to_back();
      test_w_stall();
      test_mid_burst_reset();
      test_random();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (acc_q.size() != 0 || len_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: pending desc=%0d bursts=%0d want 0 0", acc_q.size(), len_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule
